// File: rtl/inc_dec_stream.sv
// -----------------------------------------------------------------------------
// inc_dec_stream
//
// Streaming increment/decrement unit. An accepted operand a is combined with
// a runtime step:
//   in_dec = 0 : y = a + step, cout = carry out of the MSB
//   in_dec = 1 : y = a - step, cout = borrow (a < step)
// The step is zero-extended to WIDTH. The result and its flags are registered,
// so a result appears one cycle after it is accepted. Storage is one output
// register plus one skid register, and results leave in strict FIFO order.
// A counter tracks the results delivered downstream.
//
// Build option (macro INC_DEC_SAT_EN):
//   defined   : saturating. Increment overflow clamps y to all-ones, and
//               decrement underflow clamps y to zero. cout still flags the
//               event, and zero reflects the clamped y.
//   undefined : results wrap modulo 2^WIDTH (default).
//
// Parameters
//   WIDTH   operand/result width (>= 2)
//   STEP_W  step width (<= WIDTH)
//   CNT_W   delivered-result counter width
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   in_valid   in   operand valid
//   in_ready   out  unit can accept an operand this cycle
//   in_a       in   operand [WIDTH]
//   in_dec     in   0 = increment, 1 = decrement
//   in_step    in   step magnitude [STEP_W]
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   out_y      out  result [WIDTH]
//   out_cout   out  carry (increment) / borrow (decrement)
//   out_zero   out  out_y == 0
//   txn_count  out  results delivered, wraps mod 2^CNT_W [CNT_W]
// -----------------------------------------------------------------------------
module inc_dec_stream #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic              in_dec,
    input  logic [STEP_W-1:0] in_step,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_y,
    output logic              out_cout,
    output logic              out_zero,
    output logic [CNT_W-1:0]  txn_count
);

    // ---------------------------------------------------------------------
    // Step zero-extension. Each bit is chosen by position, so the structure
    // also covers STEP_W == WIDTH without a zero-width replication.
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] step_ext;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step_ext
            if (gi < STEP_W) begin : g_bit
                assign step_ext[gi] = in_step[gi];
            end else begin : g_pad
                assign step_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Arithmetic on the incoming operand. Both paths are one bit wider than
    // WIDTH. The extra bit of the sum is the carry. The extra bit of the
    // difference is set exactly when a < step, because both operands are
    // below 2^WIDTH.
    // ---------------------------------------------------------------------
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] res_y;
    logic             res_cout;
    logic             res_zero;

    always_comb begin
        sum_ext  = {1'b0, in_a} + {1'b0, step_ext};
        diff_ext = {1'b0, in_a} - {1'b0, step_ext};
        res_cout = in_dec ? diff_ext[WIDTH] : sum_ext[WIDTH];
        res_y    = in_dec ? diff_ext[WIDTH-1:0] : sum_ext[WIDTH-1:0];
`ifdef INC_DEC_SAT_EN
        if (res_cout) begin
            res_y = in_dec ? '0 : '1;
        end
`endif
        res_zero = (res_y == '0);
    end

    // ---------------------------------------------------------------------
    // Output register, skid register and counter
    // ---------------------------------------------------------------------
    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] out_y_reg,     out_y_next;
    logic             out_cout_reg,  out_cout_next;
    logic             out_zero_reg,  out_zero_next;
    logic             skid_full_reg, skid_full_next;
    logic [WIDTH-1:0] skid_y_reg,    skid_y_next;
    logic             skid_cout_reg, skid_cout_next;
    logic             skid_zero_reg, skid_zero_next;
    logic [CNT_W-1:0] txn_count_reg, txn_count_next;

    logic accept;
    logic drain;

    // in_ready is based only on registered state. The unit is never ready
    // while it is held in reset.
    assign in_ready = !skid_full_reg && !rst;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_reg && out_ready;

    always_comb begin
        out_valid_next = out_valid_reg;
        out_y_next     = out_y_reg;
        out_cout_next  = out_cout_reg;
        out_zero_next  = out_zero_reg;
        skid_full_next = skid_full_reg;
        skid_y_next    = skid_y_reg;
        skid_cout_next = skid_cout_reg;
        skid_zero_next = skid_zero_reg;
        txn_count_next = txn_count_reg;

        if (drain) begin
            txn_count_next = txn_count_reg + CNT_W'(1);
            if (skid_full_reg) begin
                // Refill from the skid register first to keep FIFO order.
                // An accept cannot occur here, because in_ready is low
                // while the skid register is full.
                out_y_next     = skid_y_reg;
                out_cout_next  = skid_cout_reg;
                out_zero_next  = skid_zero_reg;
                skid_full_next = 1'b0;
            end else if (accept) begin
                out_y_next     = res_y;
                out_cout_next  = res_cout;
                out_zero_next  = res_zero;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_reg) begin
                out_valid_next = 1'b1;
                out_y_next     = res_y;
                out_cout_next  = res_cout;
                out_zero_next  = res_zero;
            end else begin
                // The output register is stalled, so park the result.
                skid_full_next = 1'b1;
                skid_y_next    = res_y;
                skid_cout_next = res_cout;
                skid_zero_next = res_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_y_reg     <= '0;
            out_cout_reg  <= 1'b0;
            out_zero_reg  <= 1'b0;
            skid_full_reg <= 1'b0;
            skid_y_reg    <= '0;
            skid_cout_reg <= 1'b0;
            skid_zero_reg <= 1'b0;
            txn_count_reg <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_y_reg     <= out_y_next;
            out_cout_reg  <= out_cout_next;
            out_zero_reg  <= out_zero_next;
            skid_full_reg <= skid_full_next;
            skid_y_reg    <= skid_y_next;
            skid_cout_reg <= skid_cout_next;
            skid_zero_reg <= skid_zero_next;
            txn_count_reg <= txn_count_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_y     = out_y_reg;
    assign out_cout  = out_cout_reg;
    assign out_zero  = out_zero_reg;
    assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_inc_dec_stream.sv
// -----------------------------------------------------------------------------
// tb_inc_dec_stream
//
// Self-checking bench for inc_dec_stream (WIDTH=8, STEP_W=4, CNT_W=16).
// The reference model is a queue of expected results. Each result is computed
// with integer arithmetic when its operand is accepted. Queue occupancy gives
// the expected out_valid and in_ready, and the queue head gives the expected
// output fields. The bench runs directed scenarios first, then randomized
// traffic with random backpressure and occasional resets.
// -----------------------------------------------------------------------------
module tb_inc_dec_stream;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic              in_dec;
    logic [STEP_W-1:0] in_step;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_y;
    logic              out_cout;
    logic              out_zero;
    logic [CNT_W-1:0]  txn_count;

    inc_dec_stream #(
        .WIDTH (WIDTH),
        .STEP_W(STEP_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_dec   (in_dec),
        .in_step  (in_step),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .out_cout (out_cout),
        .out_zero (out_zero),
        .txn_count(txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             cout;
        logic             zero;
    } result_t;

    result_t          exp_q[$];
    logic [CNT_W-1:0] exp_cnt;
    int               n_checks;
    int               n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic, taken directly from the functional rules.
    function automatic result_t model(input int a, input bit dec, input int step);
        result_t r;
        int      s;
        int      lim;
        lim = 1 << WIDTH;
        s   = dec ? (a - step) : (a + step);
        r.cout = dec ? (a < step) : (s >= lim);
        r.y    = WIDTH'((s + lim) % lim);
`ifdef INC_DEC_SAT_EN
        if (r.cout) r.y = dec ? '0 : '1;
`endif
        r.zero = (r.y == 0);
        return r;
    endfunction

    task automatic drive(input bit v, input int a, input bit dec, input int step, input bit ordy);
        in_valid  = v;
        in_a      = WIDTH'(a);
        in_dec    = dec;
        in_step   = STEP_W'(step);
        out_ready = ordy;
    endtask

    // One clock cycle. It is called just after a falling edge, with the
    // inputs already driven. The task checks the outputs against the model,
    // advances the model with this cycle's handshakes and then waits for the
    // next falling edge.
    task automatic step();
        bit acc;
        bit drn;
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2 && !rst));
        check("txn_count", 32'(txn_count), 32'(exp_cnt));
        if (out_valid && exp_q.size() != 0) begin
            check("out_y", 32'(out_y), 32'(exp_q[0].y));
            check("out_cout", 32'(out_cout), 32'(exp_q[0].cout));
            check("out_zero", 32'(out_zero), 32'(exp_q[0].zero));
        end
        acc = in_valid && (exp_q.size() < 2) && !rst;
        drn = out_ready && (exp_q.size() != 0);
        if (rst) begin
            exp_q.delete();
            exp_cnt = '0;
        end else begin
            if (drn) begin
                void'(exp_q.pop_front());
                exp_cnt = exp_cnt + 1'b1;
            end
            if (acc) exp_q.push_back(model(int'(in_a), in_dec, int'(in_step)));
        end
        $display("cyc t=%0t vin=%0b a=%0h dec=%0b step=%0h rdy=%0b ordy=%0b ov=%0b y=%0h c=%0b z=%0b cnt=%0d",
                 $time, in_valid, in_a, in_dec, in_step, in_ready, out_ready,
                 out_valid, out_y, out_cout, out_zero, txn_count);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = '0;
        rst      = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        step();
        // The bench checks the reset state before the model takes over.
        check("rst_out_y", 32'(out_y), 32'h0);
        check("rst_cout", 32'(out_cout), 32'h0);
        check("rst_zero", 32'(out_zero), 32'h0);
        step();
        rst = 1'b0;

        // Basic increment, increment wrap and decrement with borrow.
        drive(1, 8'h05, 0, 1, 1);   step();
        drive(1, 8'hFF, 0, 1, 1);   step();
        drive(1, 8'h02, 1, 15, 1);  step();
        drive(1, 8'h40, 1, 0, 1);   step();
        drive(1, 8'h00, 0, 0, 1);   step();
        drive(0, 0, 0, 0, 1);       step();
        step();

        // Backpressure: three operands back-to-back into a stalled output.
        drive(1, 1, 0, 1, 0);       step();
        drive(1, 2, 0, 1, 0);       step();
        drive(1, 3, 0, 1, 0);       step();
        check("bp_ready_low", 32'(in_ready), 32'h0);
        step();
        step();
        drive(1, 3, 0, 1, 1);       step();
        step();
        drive(0, 0, 0, 0, 1);       step();
        step();
        step();

        // Reset with both registers full.
        drive(1, 8'h10, 0, 2, 0);   step();
        drive(1, 8'h20, 0, 2, 0);   step();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;                 step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 1);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_cnt", 32'(txn_count), 32'h0);
        step();
        step();

        // Continuous stream of 300 increments.
        for (int i = 0; i < 300; i++) begin
            drive(1, $urandom_range(0, 255), 0, $urandom_range(0, 15), 1);
            step();
        end
        drive(0, 0, 0, 0, 1);
        step();
        step();
        check("stream_cnt", 32'(txn_count), 32'd300);

        // Randomized traffic with backpressure and rare resets.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 1),
                  $urandom_range(0, 15), $urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 1);
        step();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
